// File: rtl/mem_access_sequencer_if.sv
// Two-requester load/store bus plus byte-wide memory port.
// master: requesters and memory; slave: the sequencer.
interface mem_access_sequencer_if;
  logic        req0_valid;
  logic        req0_write;
  logic [2:0]  req0_funct3;
  logic [63:0] req0_addr;
  logic [63:0] req0_wdata;
  logic        req0_ready;
  logic        req0_done;
  logic [63:0] req0_rdata;
  logic        req0_err;

  logic        req1_valid;
  logic        req1_write;
  logic [2:0]  req1_funct3;
  logic [63:0] req1_addr;
  logic [63:0] req1_wdata;
  logic        req1_ready;
  logic        req1_done;
  logic [63:0] req1_rdata;
  logic        req1_err;

  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport master (
    output req0_valid, req0_write, req0_funct3,
    output req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_funct3,
    output req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  modport slave (
    input  req0_valid, req0_write, req0_funct3,
    input  req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_funct3,
    input  req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Round-robin two-requester RV64 load/store sequencer over a byte memory.
// Ports: clk, reset_n (sync, active-low), bus (slave), busy.
module mem_access_sequencer #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic clk,
  input  logic reset_n,
  mem_access_sequencer_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;

  logic        any_v;
  logic        sel;
  logic        s_write;
  logic [2:0]  s_f3;
  logic [63:0] s_addr;
  logic [63:0] s_wdata;
  logic [3:0]  s_n;
  logic        s_mis;
  logic [64:0] s_end;
  logic        s_oor;
  logic        s_ill;
  logic [2:0]  top_idx;
  logic [63:0] ext;

  // Selection of the candidate requester and its legality check.
  always_comb begin
    any_v = bus.req0_valid | bus.req1_valid;
    sel = (bus.req0_valid & bus.req1_valid)
        ? ~last_grant_q : bus.req1_valid;
    s_write = sel ? bus.req1_write  : bus.req0_write;
    s_f3    = sel ? bus.req1_funct3 : bus.req0_funct3;
    s_addr  = sel ? bus.req1_addr   : bus.req0_addr;
    s_wdata = sel ? bus.req1_wdata  : bus.req0_wdata;
    s_n     = 4'd1 << s_f3[1:0];
    s_mis   = |(s_addr & (64'(s_n) - 64'd1));
    // 65-bit sum so huge addresses cannot wrap into range
    s_end   = {1'b0, s_addr} + 65'(s_n);
    s_oor   = s_end > 65'(MEM_BYTES);
    s_ill   = s_mis | s_oor
            | (s_write & s_f3[2])
            | (~s_write & (s_f3 == 3'b111));
  end

  assign top_idx = 3'((4'd1 << funct3_q[1:0]) - 4'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      rbuf_q       <= 64'd0;
      cnt_q        <= 3'd0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          gnt_d        = sel;
          last_grant_d = sel;
          write_d      = s_write;
          funct3_d     = s_f3;
          addr_d       = s_addr;
          wdata_d      = s_wdata;
          rbuf_d       = 64'd0;
          cnt_d        = 3'd0;
          err_d        = s_ill;
          state_d      = s_ill ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q)
          rbuf_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == top_idx)
          state_d = RESP;
      end
      RESP: begin
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy           = (state_q != IDLE);
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.req0_done  = 1'b0;
    bus.req1_done  = 1'b0;
    bus.req0_rdata = 64'd0;
    bus.req1_rdata = 64'd0;
    bus.req0_err   = 1'b0;
    bus.req1_err   = 1'b0;
    bus.mem_addr   = 64'd0;
    bus.mem_wdata  = 8'd0;
    bus.mem_we     = 1'b0;
    ext            = rbuf_q;
    unique case (funct3_q[1:0])
      2'b00: ext = {{56{~funct3_q[2] & rbuf_q[7]}},
                    rbuf_q[7:0]};
      2'b01: ext = {{48{~funct3_q[2] & rbuf_q[15]}},
                    rbuf_q[15:0]};
      2'b10: ext = {{32{~funct3_q[2] & rbuf_q[31]}},
                    rbuf_q[31:0]};
      default: ext = rbuf_q;
    endcase
    unique case (state_q)
      IDLE: begin
        // no grant while reset is asserted
        bus.req0_ready = any_v & ~sel & reset_n;
        bus.req1_ready = any_v & sel & reset_n;
      end
      ACCESS: begin
        bus.mem_addr = addr_q + {61'd0, cnt_q};
        // a reset edge must not commit the in-flight byte
        bus.mem_we   = write_q & reset_n;
        if (write_q)
          bus.mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
      end
      RESP: begin
        if (gnt_q) begin
          bus.req1_done  = 1'b1;
          bus.req1_err   = err_q;
          bus.req1_rdata = err_q ? 64'd0 : ext;
        end else begin
          bus.req0_done  = 1'b1;
          bus.req0_err   = err_q;
          bus.req0_rdata = err_q ? 64'd0 : ext;
        end
      end
      default: ;
    endcase
  end

endmodule
